regmap_bus_bridge: RTL and testbench

- Front-end stage directly upstream of the 4-bit register map. It converts a valid/ready request/response bus into the register map's single-cycle WRITE/READ strobes, plus its ADDR and WRITE_DATA buses.
- Captures READ_DATA after a fixed, parameterised read latency and returns it on a backpressurable response channel.
- Rejects out-of-range addresses with an error response and issues no strobe for them.
- Exactly one transaction is in flight at a time.

---
 rtl/regmap_pkg.sv | 18 +
 rtl/regmap_bus_bridge.sv | 135 +++++++++++++
 tb/tb_regmap_bus_bridge.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regmap_pkg.sv
// Shared definitions for the 4-bit register map and its bus bridge.
//   AW_DEF / DW_DEF   : default address / data widths of the register map.
//   REGMAP_MAX_ADDR   : highest implemented register address.
//   state_t           : bridge FSM states.
package regmap_pkg;

  localparam int AW_DEF          = 3;
  localparam int DW_DEF          = 4;
  localparam int REGMAP_MAX_ADDR = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/regmap_bus_bridge.sv
// Bus bridge in front of the register map. Accepts one valid/ready request
// at a time, turns it into a single-cycle WRITE or READ strobe with
// registered ADDR / WRITE_DATA, samples READ_DATA RD_LAT cycles after the
// READ strobe, and returns the result on a backpressurable response channel.
// Addresses above MAX_ADDR are answered with RSP_ERR and never strobed.
//
// Ports:
//   CLK, RST                     clock (rising edge), synchronous active-high reset
//   REQ_VALID/REQ_READY          request handshake
//   REQ_WRITE, REQ_ADDR, REQ_WDATA  request payload
//   RSP_VALID/RSP_READY          response handshake
//   RSP_RDATA, RSP_ERR           response payload
//   WRITE, READ                  one-cycle strobes to the register map
//   ADDR, WRITE_DATA             registered address / write data to the map
//   READ_DATA                    read data from the map
module regmap_bus_bridge
  import regmap_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_ADDR = REGMAP_MAX_ADDR,
  parameter int RD_LAT   = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic          REQ_WRITE,
  input  logic [AW-1:0] REQ_ADDR,
  input  logic [DW-1:0] REQ_WDATA,
  output logic          RSP_VALID,
  input  logic          RSP_READY,
  output logic [DW-1:0] RSP_RDATA,
  output logic          RSP_ERR,
  output logic          WRITE,
  output logic          READ,
  output logic [AW-1:0] ADDR,
  output logic [DW-1:0] WRITE_DATA,
  input  logic [DW-1:0] READ_DATA
);

  localparam logic [AW-1:0] MAX_A    = AW'(MAX_ADDR);
  localparam int            LAT_M1   = (RD_LAT > 0) ? RD_LAT - 1 : 0;
  localparam logic [2:0]    LAT_LOAD = 3'(LAT_M1);

  state_t     state;
  logic       is_write;
  logic [2:0] lat_cnt;
  logic       req_in_range;

  assign req_in_range = (REQ_ADDR <= MAX_A);

  // NOTE: every register here is assigned with <= so all of them update
  // together on the edge; a blocking = would let later statements see the
  // new value within the same edge and silently reorder the pipeline.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      is_write   <= 1'b0;
      lat_cnt    <= '0;
      REQ_READY  <= 1'b0;
      RSP_VALID  <= 1'b0;
      RSP_RDATA  <= '0;
      RSP_ERR    <= 1'b0;
      WRITE      <= 1'b0;
      READ       <= 1'b0;
      ADDR       <= '0;
      WRITE_DATA <= '0;
    end else begin
      // Strobes are single-cycle pulses; they only rise on the accept edge.
      WRITE <= 1'b0;
      READ  <= 1'b0;

      case (state)
        IDLE: begin
          REQ_READY <= 1'b1;
          if (REQ_VALID && REQ_READY) begin
            is_write   <= REQ_WRITE;
            ADDR       <= REQ_ADDR;
            WRITE_DATA <= REQ_WDATA;
            REQ_READY  <= 1'b0;
            // Outputs are registered, so the strobe for the ISSUE cycle is
            // decided here from the request being accepted.
            WRITE      <= REQ_WRITE && req_in_range;
            READ       <= !REQ_WRITE && req_in_range;
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          if (ADDR > MAX_A) begin
            RSP_ERR   <= 1'b1;
            RSP_RDATA <= '0;
            RSP_VALID <= 1'b1;
            state     <= RESP;
          end else if (is_write) begin
            RSP_RDATA <= '0;
            RSP_VALID <= 1'b1;
            state     <= RESP;
          end else if (RD_LAT == 0) begin
            // Zero latency: the map answers within the READ cycle itself.
            RSP_RDATA <= READ_DATA;
            RSP_VALID <= 1'b1;
            state     <= RESP;
          end else begin
            lat_cnt <= LAT_LOAD;
            state   <= WAIT;
          end
        end

        WAIT: begin
          if (lat_cnt == 3'd0) begin
            RSP_RDATA <= READ_DATA;
            RSP_VALID <= 1'b1;
            state     <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            RSP_ERR   <= 1'b0;
            REQ_READY <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regmap_bus_bridge.sv
// Self-checking bench for regmap_bus_bridge. Three bridges run side by side
// with RD_LAT = 0, 1 and 3, each in front of a small register-map model that
// only presents valid READ_DATA in the exact cycle it should be sampled.
// Expected responses come from a transaction-level model (ref_mem plus the
// latency rules), not from the DUT.
module tb_regmap_bus_bridge;

  localparam int NL    = 3;
  localparam int MAX_A = 1;

  function automatic int lat_of(input int l);
    return (l == 0) ? 0 : ((l == 1) ? 1 : 3);
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NL-1:0]       req_valid = '0;
  logic [NL-1:0]       req_ready;
  logic [NL-1:0]       req_write = '0;
  logic [NL-1:0][2:0]  req_addr  = '0;
  logic [NL-1:0][3:0]  req_wdata = '0;
  logic [NL-1:0]       rsp_valid;
  logic [NL-1:0]       rsp_ready = '0;
  logic [NL-1:0][3:0]  rsp_rdata;
  logic [NL-1:0]       rsp_err;
  logic [NL-1:0]       write_s;
  logic [NL-1:0]       read_s;
  logic [NL-1:0][2:0]  addr_s;
  logic [NL-1:0][3:0]  wdata_s;
  logic [NL-1:0][3:0]  read_data;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int both_cnt = 0;

  logic [3:0] ref_mem [NL][2];

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

    regmap_bus_bridge #(.RD_LAT(LAT)) dut (
      .CLK        (clk),
      .RST        (rst),
      .REQ_VALID  (req_valid[g]),
      .REQ_READY  (req_ready[g]),
      .REQ_WRITE  (req_write[g]),
      .REQ_ADDR   (req_addr[g]),
      .REQ_WDATA  (req_wdata[g]),
      .RSP_VALID  (rsp_valid[g]),
      .RSP_READY  (rsp_ready[g]),
      .RSP_RDATA  (rsp_rdata[g]),
      .RSP_ERR    (rsp_err[g]),
      .WRITE      (write_s[g]),
      .READ       (read_s[g]),
      .ADDR       (addr_s[g]),
      .WRITE_DATA (wdata_s[g]),
      .READ_DATA  (read_data[g])
    );

    // Register map model: two registers written by the WRITE strobe.
    logic [3:0]  mem [2] = '{default: 4'h0};
    logic [3:0]  junk = 4'h0;
    logic        rd_pend = 1'b0;
    int unsigned rd_cyc = 0;
    logic        hit;

    always @(posedge clk) begin
      if (write_s[g]) mem[addr_s[g][0]] <= wdata_s[g];
      junk <= 4'($urandom);
      if (rst) rd_pend <= 1'b0;
      else if (read_s[g]) begin
        rd_pend <= 1'b1;
        rd_cyc  <= cyc;
      end
    end

    // Valid data only in the cycle exactly LAT cycles after the READ cycle;
    // anything else is random garbage.
    assign hit = (LAT == 0) ? read_s[g] : (rd_pend && (cyc == rd_cyc + LAT));
    assign read_data[g] = hit ? mem[addr_s[g][0]] : junk;
  end

  always @(negedge clk) if ((write_s & read_s) != '0) both_cnt++;

  task automatic check_zero(input int l, input string name);
    logic [17:0] got;
    got = {req_ready[l], rsp_valid[l], rsp_rdata[l], rsp_err[l], write_s[l],
           read_s[l], addr_s[l], wdata_s[l]};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s lane%0d outputs got %h want 0", name, l, got);
    end
  endtask

  // One complete transaction on lane l. Optionally presents a follow-up
  // request while the response is held, which must not be accepted early.
  task automatic do_txn(input int l, input bit wr, input logic [2:0] a,
                        input logic [3:0] d, input int hold,
                        input bit nxt_en, input bit nxt_wr,
                        input logic [2:0] nxt_a, input logic [3:0] nxt_d,
                        output int waited);
    bit ok, rd_ok;
    int exp_k, k, extra;
    logic [3:0] exp_rd, hold_rd;
    logic hold_err;
    ok     = (int'(a) <= MAX_A);
    rd_ok  = ok && !wr;
    exp_k  = rd_ok ? 2 + lat_of(l) : 2;
    exp_rd = rd_ok ? ref_mem[l][a[0]] : 4'h0;
    if (ok && wr) ref_mem[l][a[0]] = d;

    req_valid[l] = 1'b1;
    req_write[l] = wr;
    req_addr[l]  = a;
    req_wdata[l] = d;
    waited = 0;
    while (req_ready[l] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 20) begin
      errors++;
      $display("FAIL accept_timeout lane%0d got ready=%b want 1", l, req_ready[l]);
      req_valid[l] = 1'b0;
      return;
    end

    @(negedge clk);  // cycle T+1
    req_valid[l] = 1'b0;
    checks++;
    if ({write_s[l], read_s[l], req_ready[l]} !== {ok && wr, rd_ok, 1'b0}) begin
      errors++;
      $display("FAIL strobe lane%0d got w/r/rdy=%b%b%b want %b%b0", l,
               write_s[l], read_s[l], req_ready[l], ok && wr, rd_ok);
    end
    checks++;
    if (addr_s[l] !== a || wdata_s[l] !== d) begin
      errors++;
      $display("FAIL map_bus lane%0d got addr=%h wdata=%h want addr=%h wdata=%h",
               l, addr_s[l], wdata_s[l], a, d);
    end

    k = 1;
    extra = 0;
    while (k < 30) begin
      @(negedge clk);
      k++;
      if (write_s[l] || read_s[l]) extra++;
      if (rsp_valid[l] === 1'b1) break;
    end
    checks++;
    if (k !== exp_k) begin
      errors++;
      $display("FAIL rsp_latency lane%0d got T+%0d want T+%0d", l, k, exp_k);
      if (k >= 30) return;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL extra_strobe lane%0d got %0d want 0", l, extra);
    end
    checks++;
    if (rsp_rdata[l] !== exp_rd || rsp_err[l] !== !ok) begin
      errors++;
      $display("FAIL rsp_data lane%0d got rdata=%h err=%b want rdata=%h err=%b",
               l, rsp_rdata[l], rsp_err[l], exp_rd, !ok);
    end

    hold_rd  = rsp_rdata[l];
    hold_err = rsp_err[l];
    if (nxt_en) begin
      req_valid[l] = 1'b1;
      req_write[l] = nxt_wr;
      req_addr[l]  = nxt_a;
      req_wdata[l] = nxt_d;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid[l], rsp_rdata[l], rsp_err[l], req_ready[l], write_s[l], read_s[l]}
          !== {1'b1, hold_rd, hold_err, 3'b000}) begin
        errors++;
        $display("FAIL rsp_hold lane%0d cyc%0d got v=%b d=%h e=%b rdy=%b w=%b r=%b want v=1 d=%h e=%b rdy=0 w=0 r=0",
                 l, i, rsp_valid[l], rsp_rdata[l], rsp_err[l], req_ready[l],
                 write_s[l], read_s[l], hold_rd, hold_err);
      end
    end

    rsp_ready[l] = 1'b1;
    @(negedge clk);
    rsp_ready[l] = 1'b0;
    checks++;
    if ({rsp_valid[l], rsp_err[l], req_ready[l], write_s[l], read_s[l]} !== 5'b00100) begin
      errors++;
      $display("FAIL after_handshake lane%0d got v/e/rdy/w/r=%b%b%b%b%b want 00100",
               l, rsp_valid[l], rsp_err[l], req_ready[l], write_s[l], read_s[l]);
    end
  endtask

  task automatic txn(input int l, input bit wr, input logic [2:0] a,
                     input logic [3:0] d, input int hold);
    int w;
    do_txn(l, wr, a, d, hold, 1'b0, 1'b0, 3'd0, 4'd0, w);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int l = 0; l < NL; l++) check_zero(l, "reset");
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== {NL{1'b1}} || rsp_valid !== '0) begin
      errors++;
      $display("FAIL reset_release got ready=%b valid=%b want ready=111 valid=000",
               req_ready, rsp_valid);
    end
  endtask

  task automatic test_write();
    txn(1, 1'b1, 3'd1, 4'hA, 0);
  endtask

  task automatic test_read();
    txn(1, 1'b1, 3'd1, 4'h5, 0);
    txn(1, 1'b0, 3'd1, 4'h0, 0);
    txn(2, 1'b1, 3'd0, 4'h9, 1);
    txn(2, 1'b0, 3'd0, 4'h2, 2);
  endtask

  task automatic test_error();
    txn(1, 1'b1, 3'd3, 4'hF, 0);
    txn(1, 1'b0, 3'd7, 4'h6, 1);
    txn(0, 1'b0, 3'd2, 4'h1, 0);
  endtask

  task automatic test_held_request();
    int w;
    do_txn(1, 1'b0, 3'd1, 4'h0, 5, 1'b1, 1'b1, 3'd0, 4'hC, w);
    do_txn(1, 1'b1, 3'd0, 4'hC, 0, 1'b0, 1'b0, 3'd0, 4'h0, w);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL held_accept got wait=%0d want 0", w);
    end
  endtask

  task automatic test_reset_mid_read();
    int w, seen;
    req_valid[2] = 1'b1;
    req_write[2] = 1'b0;
    req_addr[2]  = 3'd0;
    req_wdata[2] = 4'h0;
    w = 0;
    while (req_ready[2] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);  // ISSUE
    req_valid[2] = 1'b0;
    @(negedge clk);  // WAIT
    rst = 1'b1;
    @(negedge clk);
    check_zero(2, "mid_reset");
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_release got ready=%b want 1", req_ready[2]);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid[2] || write_s[2] || read_s[2]) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abandoned_read got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    txn(0, 1'b1, 3'd0, 4'h3, 0);
    txn(0, 1'b0, 3'd0, 4'h0, 0);
    checks++;
    if (ref_mem[0][0] !== 4'h3) begin
      errors++;
      $display("FAIL b2b_model got %h want 3", ref_mem[0][0]);
    end
  endtask

  task automatic test_random();
    int l;
    logic [2:0] a;
    for (int n = 0; n < 60; n++) begin
      l = int'($urandom_range(0, NL - 1));
      a = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7))
                                      : 3'($urandom_range(0, 1));
      txn(l, 1'($urandom), a, 4'($urandom), int'($urandom_range(0, 3)));
    end
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL write_read_overlap got %0d cycles want 0", both_cnt);
    end
  endtask

  initial begin
    for (int l = 0; l < NL; l++) begin
      ref_mem[l][0] = 4'h0;
      ref_mem[l][1] = 4'h0;
    end
    test_reset();
    test_write();
    test_read();
    test_error();
    test_held_request();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
